lfsr_checker: RTL

Receive-side companion to the team's free-running LFSR generator. Consumes the generated sequence as a serial bit stream (generator's new LSB each beat) and self-synchronises by seeding its own shift register from the first WIDTH received bits. After seeding it predicts every following bit, flags mismatches and keeps saturating error and bit counters. It declares loss of lock on an excessive error rate and re-seeds. Used for link and BIST checking at the far end of a PRBS path.

---
 rtl/lfsr_pkg.sv | 30 +++
 rtl/sat_counter.sv | 42 ++++
 rtl/lfsr_checker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the PRBS generator / checker pair.
//   chk_state_e : checker FSM states (SEED, CHECK)
//   LFSR_WIDTH  : default LFSR length
//   LFSR_TAP    : default second feedback tap
//   lfsr_fb()   : feedback bit = sr[msb] ^ sr[tap]. The generator and the
//                 checker both call it so they cannot diverge.
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } chk_state_e;

    localparam int LFSR_WIDTH = 10;
    localparam int LFSR_TAP   = 6;

    // The shift register is passed zero-extended to this width, so one
    // function serves every LFSR length up to 32.
    localparam int LFSR_MAX_W = 32;

    function automatic logic lfsr_fb(input logic [LFSR_MAX_W-1:0] sr,
                                     input logic [4:0]            msb,
                                     input logic [4:0]            tap);
        return sr[msb] ^ sr[tap];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (count -> 0)
//   inc_i  : add one this cycle (held at all-ones once reached)
//   clr_i  : synchronous clear, wins over inc_i
//   cnt_o  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Receive-side PRBS checker. Seeds its shift register from the first WIDTH
// valid bits, then predicts every following bit, flags mismatches and keeps
// saturating error / checked-bit counters. Too many errors inside one window
// drops lock and forces a re-seed.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_bit carries a sequence bit this cycle
//   in_bit     : received sequence bit
//   clr        : synchronous clear of err_count / bit_count (lock untouched)
//   locked     : high while in CHECK
//   err_pulse  : registered one-cycle pulse per mismatching beat
//   err_count  : saturating mismatch count
//   bit_count  : saturating checked-beat count
//
// Handshake: in_valid is a one-sided qualifier; every cycle with in_valid=1
// is consumed, there is no back-pressure. Cycles with in_valid=0 leave all
// state untouched.
// -----------------------------------------------------------------------------
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int WIDTH       = LFSR_WIDTH,
    parameter int TAP         = LFSR_TAP,
    parameter int CNT_W       = 16,
    parameter int LOSS_WIN    = 64,
    parameter int LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int WC_W   = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
    // Must hold LOSS_THRESH itself, the value of win_err_next at the trip.
    localparam int WE_W   = $clog2(LOSS_THRESH + 1);

    chk_state_e        state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
    logic [WE_W-1:0]   win_err_q, win_err_d;
    logic              err_pulse_q, err_pulse_d;

    logic              exp_bit;
    logic              mis;
    logic [WIDTH-1:0]  seed_sr;
    logic [WE_W-1:0]   win_err_next;
    logic              inc_bit;
    logic              inc_err;

    assign exp_bit      = lfsr_fb(LFSR_MAX_W'(sr_q), 5'(WIDTH - 1), 5'(TAP));
    assign mis          = in_bit ^ exp_bit;
    assign seed_sr      = {sr_q[WIDTH-2:0], in_bit};
    assign win_err_next = win_err_q + WE_W'(mis);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        inc_bit     = 1'b0;
        inc_err     = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                SEED: begin
                    sr_d = seed_sr;
                    if (fill_q == FILL_W'(WIDTH - 1)) begin
                        fill_d = '0;
                        // An all-zero register is the XOR lock-up state and
                        // can never reproduce the sequence: seed again.
                        if (|seed_sr) begin
                            state_d = CHECK;
                        end
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                CHECK: begin
                    // Shift in the prediction, not the received bit, so a
                    // single line error does not corrupt later predictions.
                    sr_d        = {sr_q[WIDTH-2:0], exp_bit};
                    err_pulse_d = mis;
                    inc_bit     = 1'b1;
                    inc_err     = mis;
                    if (win_err_next >= WE_W'(LOSS_THRESH)) begin
                        state_d   = SEED;
                        fill_d    = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == WC_W'(LOSS_WIN - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = win_err_next;
                    end
                end
                default: begin
                    state_d = SEED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEED;
            sr_q        <= '0;
            fill_q      <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (inc_err),
        .clr_i (clr),
        .cnt_o (err_count)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (inc_bit),
        .clr_i (clr),
        .cnt_o (bit_count)
    );

    assign locked    = (state_q == CHECK);
    assign err_pulse = err_pulse_q;

endmodule
